mux_diag_sequencer: RTL

- Sequences exhaustive diagnosis of the gate-level 2:1 mux netlist (`mux_proper`, 9 observable nets).
- On `start`, drives all 8 input vectors (I0, I1, S) into the DUT and compares the 9 observed nets against an internally computed golden model.
- Intersects fan-in-cone masks to narrow the suspected fault sites, then reports the candidate mask and summary flags.
- Sits between the diagnosis top level and the mux DUT; replaces bench-only diagnosis with synthesizable RTL.

---
 rtl/mux_diag_pkg.sv | 67 ++++++
 rtl/mux_diag_cmp.sv | 41 ++++
 rtl/mux_diag_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mux_diag_pkg.sv
// ---------------------------------------------------------------------------
// mux_diag_pkg
// Shared definitions for the gate-level 2:1 mux diagnosis sequencer.
//   state_t    - sequencer FSM states
//   NUM_NETS   - observable nets in the mux netlist (9)
//   NUM_VEC    - exhaustive input vectors {I0, I1, S} (8)
//   CONE       - fan-in cone of each net (bit k = net k)
//   golden()   - fault-free value of all 9 nets for one input vector
//   cone_of()  - cone lookup by net index, all-ones for out-of-range index
//
// Net numbering:
//   0:I0  1:I1  2:S stem  3:S->AND(I1)  4:S->INV  5:~S
//   6:I1&S  7:I0&~S  8:out
// ---------------------------------------------------------------------------
package mux_diag_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        APPLY   = 3'd1,
        SETTLE  = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int NUM_NETS = 9;
    localparam int NUM_VEC  = 8;

    // A fault at net k can only be observed on nets downstream of it, so the
    // highest-numbered mismatching net bounds the suspects to its fan-in cone.
    localparam logic [8:0] CONE [NUM_NETS] = '{
        9'h001,   // 0: I0
        9'h002,   // 1: I1
        9'h004,   // 2: S stem
        9'h00C,   // 3: S branch to I1 gate
        9'h014,   // 4: S branch to inverter
        9'h034,   // 5: ~S
        9'h04E,   // 6: I1 & S
        9'h0B5,   // 7: I0 & ~S
        9'h1FF    // 8: out
    };

    function automatic logic [8:0] golden(input logic i0, input logic i1, input logic s);
        logic [8:0] g;
        g[0] = i0;
        g[1] = i1;
        g[2] = s;
        g[3] = s;
        g[4] = s;
        g[5] = ~g[4];
        g[6] = g[1] & g[3];
        g[7] = g[0] & g[5];
        g[8] = g[6] | g[7];
        return g;
    endfunction

    function automatic logic [8:0] cone_of(input logic [3:0] idx);
        logic [8:0] m;
        m = CONE[NUM_NETS-1];
        for (int k = 0; k < NUM_NETS; k++) begin
            if (idx == 4'(k)) begin
                m = CONE[k];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/mux_diag_cmp.sv
// ---------------------------------------------------------------------------
// mux_diag_cmp
// Combinational compare stage: computes the golden net values for the vector
// currently driven into the mux, XORs them against the observed nets and
// priority-encodes the highest mismatching net.
//
// Ports:
//   i0, i1, s  in   1  vector currently driven into the mux
//   obs        in   9  observed nets (bit k = net k)
//   mm_any     out  1  at least one net mismatches
//   idx        out  4  highest mismatching net (0 when mm_any=0)
//   cone       out  9  fan-in cone of net idx
// ---------------------------------------------------------------------------
module mux_diag_cmp
    import mux_diag_pkg::*;
(
    input  logic       i0,
    input  logic       i1,
    input  logic       s,
    input  logic [8:0] obs,
    output logic       mm_any,
    output logic [3:0] idx,
    output logic [8:0] cone
);

    logic [8:0] mm;

    always_comb begin
        mm     = obs ^ golden(i0, i1, s);
        mm_any = |mm;
        idx    = 4'd0;
        // Ascending scan: the last hit is the highest set bit.
        for (int k = 0; k < NUM_NETS; k++) begin
            if (mm[k]) begin
                idx = 4'(k);
            end
        end
        cone = cone_of(idx);
    end

endmodule

// File: rtl/mux_diag_sequencer.sv
// ---------------------------------------------------------------------------
// mux_diag_sequencer
// Drives all 8 input vectors into the gate-level 2:1 mux, compares the 9
// observed nets against a golden model and narrows the suspected fault sites
// by intersecting fan-in cones.
//
// Parameters:
//   SETTLE_CYCLES  cycles between vector drive and observation (1..15)
//
// Ports:
//   clk             in   1  system clock, rising edge
//   rst             in   1  asynchronous active-high reset
//   start           in   1  launch a run (sampled in IDLE only)
//   dut_i0          out  1  mux data input 0 (vec[2])
//   dut_i1          out  1  mux data input 1 (vec[1])
//   dut_s           out  1  mux select (vec[0])
//   obs             in   9  observed nets, used only in COMPARE
//   busy            out  1  run in progress
//   done            out  1  one-cycle completion pulse
//   cand            out  9  remaining suspect nets
//   fail            out  1  any mismatch seen in the current/last run
//   first_fail_vec  out  3  vector of the first mismatch
//   mismatch_cnt    out  4  vectors with any mismatch
//
// State    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | results held, waiting for start
// APPLY    | drive vec onto the mux inputs, load settle timer
// SETTLE   | inputs held while the netlist settles
// COMPARE  | sample obs, update suspects/status, advance or finish
// DONE     | done pulse, busy low, back to IDLE
//
// Per-vector period is SETTLE_CYCLES+2 cycles.
// ---------------------------------------------------------------------------
module mux_diag_sequencer
    import mux_diag_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_i0,
    output logic       dut_i1,
    output logic       dut_s,
    input  logic [8:0] obs,
    output logic       busy,
    output logic       done,
    output logic [8:0] cand,
    output logic       fail,
    output logic [2:0] first_fail_vec,
    output logic [3:0] mismatch_cnt
);

    state_t     state;
    logic [2:0] vec;
    logic [3:0] settle_cnt;

    logic       mm_any;
    logic [3:0] mm_idx;
    logic [8:0] mm_cone;

    // Golden model is evaluated on the registered mux inputs, which hold the
    // vector under test from APPLY through COMPARE.
    mux_diag_cmp u_cmp (
        .i0     (dut_i0),
        .i1     (dut_i1),
        .s      (dut_s),
        .obs    (obs),
        .mm_any (mm_any),
        .idx    (mm_idx),
        .cone   (mm_cone)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            vec            <= 3'd0;
            settle_cnt     <= 4'd0;
            dut_i0         <= 1'b0;
            dut_i1         <= 1'b0;
            dut_s          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cand           <= 9'h1FF;
            fail           <= 1'b0;
            first_fail_vec <= 3'd0;
            mismatch_cnt   <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cand           <= 9'h1FF;
                        fail           <= 1'b0;
                        first_fail_vec <= 3'd0;
                        mismatch_cnt   <= 4'd0;
                        vec            <= 3'd0;
                        busy           <= 1'b1;
                        state          <= APPLY;
                    end
                end

                APPLY: begin
                    dut_i0     <= vec[2];
                    dut_i1     <= vec[1];
                    dut_s      <= vec[0];
                    settle_cnt <= SETTLE_CYCLES[3:0];
                    state      <= SETTLE;
                end

                SETTLE: begin
                    // Down-counter; the terminal compare also guards a zero load.
                    if (settle_cnt <= 4'd1) begin
                        state <= COMPARE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                COMPARE: begin
                    if (mm_any) begin
                        cand         <= cand & mm_cone;
                        mismatch_cnt <= mismatch_cnt + 4'd1;
                        if (!fail) begin
                            fail           <= 1'b1;
                            first_fail_vec <= vec;
                        end
                    end
                    if (vec == 3'(NUM_VEC - 1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        vec   <= vec + 3'd1;
                        state <= APPLY;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
